// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, memory arbiter states and defaults.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    localparam int BURST_WORDS  = 2;
    localparam int STARVE_LIMIT = 3;
    localparam int ADDR_W       = 32;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares the single RAM port between icache and dcache: burst-held grants,
// dcache priority, and a starvation guard that eventually favours the icache.
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int BURST_WORDS  = cpu_types_pkg::BURST_WORDS,
    parameter int STARVE_LIMIT = cpu_types_pkg::STARVE_LIMIT,
    parameter int ADDR_W       = cpu_types_pkg::ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [ADDR_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic              dwait,
    output logic [ADDR_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  ramstate_t         ramstate
);

    localparam int BW = $clog2(BURST_WORDS + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_WORDS - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t    state, state_next;
    logic [BW-1:0] burst_cnt, burst_next;
    logic [SW-1:0] starve_cnt, starve_next;
    logic          dreq;
    logic          access;

    assign dreq   = dREN | dWEN;
    assign access = (ramstate == ACCESS);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            burst_cnt  <= burst_next;
            starve_cnt <= starve_next;
        end
    end

    always_comb begin
        state_next  = state;
        burst_next  = burst_cnt;
        starve_next = starve_cnt;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iwait       = 1'b1;
        dwait       = 1'b1;
        iload       = '0;
        dload       = '0;

        case (state)
            IDLE: begin
                if (dreq && (!iREN || starve_cnt < STARVE_MAX)) begin
                    state_next = DGRANT;
                end else if (iREN) begin
                    state_next = IGRANT;
                end
            end

            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                // A dcache burst that ends while the icache waits counts toward starvation.
                if (access) begin
                    dwait = 1'b0;
                    dload = ramload;
                    if (burst_cnt == BURST_LAST) begin
                        state_next = IDLE;
                        burst_next = '0;
                        if (iREN && starve_cnt != STARVE_MAX) begin
                            starve_next = starve_cnt + 1'b1;
                        end
                    end else begin
                        burst_next = burst_cnt + 1'b1;
                    end
                end else if (!dreq) begin
                    state_next = IDLE;
                    burst_next = '0;
                    if (iREN && starve_cnt != STARVE_MAX) begin
                        starve_next = starve_cnt + 1'b1;
                    end
                end
            end

            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (access) begin
                    iwait       = 1'b0;
                    iload       = ramload;
                    starve_next = '0;
                    if (burst_cnt == BURST_LAST) begin
                        state_next = IDLE;
                        burst_next = '0;
                    end else begin
                        burst_next = burst_cnt + 1'b1;
                    end
                end else if (!iREN) begin
                    state_next = IDLE;
                    burst_next = '0;
                end
            end

            default: begin
                state_next = IDLE;
                burst_next = '0;
            end
        endcase
    end

endmodule
